// File: rtl/c_phit_deserializer_pkg.sv
// Shared constants and helpers for the phit deserializer slice.
package c_phit_deserializer_pkg;

  // Reset is active-low throughout this block.
  localparam logic RESET_ASSERTED = 1'b0;

  // Ceiling log2; clogb(1) = 0.
  function automatic int unsigned clogb(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/c_phit_deserializer_if.sv
// Phit-in / word-out handshake bundle for the deserializer.
interface c_phit_deserializer_if
  import c_phit_deserializer_pkg::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned phit_width = 8
);
  logic                  phit_valid_in;
  logic                  phit_first_in;
  logic [0:phit_width-1] phit_data_in;
  logic                  phit_ready_out;
  logic                  word_valid_out;
  logic [0:width-1]      word_data_out;
  logic                  word_ready_in;
  logic                  error_out;

  // Environment side: sends phits, consumes words.
  modport master (
    output phit_valid_in, phit_first_in, phit_data_in, word_ready_in,
    input  phit_ready_out, word_valid_out, word_data_out, error_out
  );

  // Deserializer side.
  modport slave (
    input  phit_valid_in, phit_first_in, phit_data_in, word_ready_in,
    output phit_ready_out, word_valid_out, word_data_out, error_out
  );
endinterface

// File: rtl/c_phit_slot_mux.sv
// Places one phit at the bit range of a slot index, honouring phit order.
module c_phit_slot_mux
  import c_phit_deserializer_pkg::*;
#(
  parameter int unsigned width         = 32,
  parameter int unsigned phit_width    = 8,
  parameter bit          reverse_order = 1'b0,
  parameter int unsigned cnt_width     = 2
) (
  input  logic [cnt_width-1:0]  slot_i,
  input  logic [0:phit_width-1] data_i,
  output logic [0:width-1]      data_o,
  output logic [0:width-1]      mask_o
);
  localparam int unsigned num_phits = width / phit_width;

  // Decode the slot, mirror it for reversed order, and drop the phit there.
  always_comb begin
    int unsigned phys;
    data_o = '0;
    mask_o = '0;
    phys   = 0;
    for (int unsigned j = 0; j < num_phits; j++) begin
      if (slot_i == cnt_width'(j)) begin
        phys = reverse_order ? (num_phits - 1 - j) : j;
        data_o[phys*phit_width +: phit_width] = data_i;
        mask_o[phys*phit_width +: phit_width] = {phit_width{1'b1}};
      end
    end
  end
endmodule

// File: rtl/c_phit_deserializer.sv
// Reassembles phits into full-width words with a one-word output register.
module c_phit_deserializer
  import c_phit_deserializer_pkg::*;
#(
  parameter int unsigned width         = 32,
  parameter int unsigned phit_width    = 8,
  parameter bit          reverse_order = 1'b0
) (
  input  logic clk,
  input  logic reset,
  c_phit_deserializer_if.slave bus
);
  localparam int unsigned num_phits = width / phit_width;
  localparam int unsigned cnt_width = (clogb(num_phits) > 1) ? clogb(num_phits) : 1;
  localparam int unsigned buf_width = (num_phits > 1) ? width - phit_width : 1;
  localparam logic [cnt_width-1:0] last_slot = cnt_width'(num_phits - 1);

  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [0:buf_width-1] buf_q, buf_d;
  logic [0:width-1]     word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 acc, take, complete;
  logic [cnt_width-1:0] slot;
  logic [0:width-1]     placed, mask, full_buf, merged;

  assign bus.phit_ready_out = !(cnt_q == last_slot && valid_q && !bus.word_ready_in);
  assign bus.word_valid_out = valid_q;
  assign bus.word_data_out  = word_q;
  assign bus.error_out      = err_q;

  c_phit_slot_mux #(
    .width        (width),
    .phit_width   (phit_width),
    .reverse_order(reverse_order),
    .cnt_width    (cnt_width)
  ) u_slot_mux (
    .slot_i(slot),
    .data_i(bus.phit_data_in),
    .data_o(placed),
    .mask_o(mask)
  );

  // The buffer covers every slot except the one the last phit lands in, so
  // its position within the word depends on the phit order.
  if (num_phits == 1) begin : g_single
    assign full_buf = '0;
    assign buf_d    = buf_q;
  end else begin : g_multi
    if (reverse_order) begin : g_rev
      assign full_buf = {{phit_width{1'b0}}, buf_q};
      assign buf_d    = take ? merged[phit_width:width-1] : buf_q;
    end else begin : g_fwd
      assign full_buf = {buf_q, {phit_width{1'b0}}};
      assign buf_d    = take ? merged[0:width-phit_width-1] : buf_q;
    end
  end

  // Accept/framing decisions, counter advance and output-register update.
  always_comb begin
    acc      = bus.phit_valid_in && bus.phit_ready_out;
    slot     = bus.phit_first_in ? '0 : cnt_q;
    take     = acc && (bus.phit_first_in || cnt_q != '0);
    complete = take && (slot == last_slot);
    err_d    = acc && ((bus.phit_first_in && cnt_q != '0) ||
                       (!bus.phit_first_in && cnt_q == '0));
    merged   = (full_buf & ~mask) | placed;

    cnt_d = cnt_q;
    if (take) cnt_d = complete ? '0 : slot + cnt_width'(1);

    word_d  = word_q;
    valid_d = valid_q;
    if (complete) begin
      word_d  = merged;
      valid_d = 1'b1;
    end else if (valid_q && bus.word_ready_in) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ASSERTED) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_c_phit_deserializer.sv
// Bench for c_phit_deserializer: forward and reversed instances share stimulus
// and are each compared against a phit-list reference model every cycle.
module tb_c_phit_deserializer;
  logic       clk;
  logic       rst_n;
  logic       v, f, wr;
  logic [7:0] d;

  int vectors;
  int miscompares;

  c_phit_deserializer_if #(.width(32), .phit_width(8)) bus0 ();
  c_phit_deserializer_if #(.width(32), .phit_width(8)) bus1 ();

  assign bus0.phit_valid_in = v;
  assign bus0.phit_first_in = f;
  assign bus0.phit_data_in  = d;
  assign bus0.word_ready_in = wr;
  assign bus1.phit_valid_in = v;
  assign bus1.phit_first_in = f;
  assign bus1.phit_data_in  = d;
  assign bus1.word_ready_in = wr;

  c_phit_deserializer #(.width(32), .phit_width(8), .reverse_order(1'b0)) u_fwd (
    .clk(clk), .reset(rst_n), .bus(bus0.slave));
  c_phit_deserializer #(.width(32), .phit_width(8), .reverse_order(1'b1)) u_rev (
    .clk(clk), .reset(rst_n), .bus(bus1.slave));

  logic        o_rdy [2];
  logic        o_val [2];
  logic        o_err [2];
  logic [31:0] o_word[2];
  assign o_rdy[0] = bus0.phit_ready_out;  assign o_rdy[1] = bus1.phit_ready_out;
  assign o_val[0] = bus0.word_valid_out;  assign o_val[1] = bus1.word_valid_out;
  assign o_err[0] = bus0.error_out;       assign o_err[1] = bus1.error_out;
  assign o_word[0] = bus0.word_data_out;  assign o_word[1] = bus1.word_data_out;

  // Reference model: list of phits collected for the current word.
  int          mlen [2];
  logic [7:0]  mph  [2][4];
  logic        mval [2];
  logic [31:0] mword[2];
  logic        merr [2];
  logic        erdy [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mlen[m] = 0; mval[m] = 1'b0; mword[m] = '0; merr[m] = 1'b0;
    end
  endtask

  // Word from collected phits: normal order puts phit 0 most significant,
  // reversed order puts phit 0 least significant.
  function automatic logic [31:0] assemble(input int m);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      w = (w << 8) | 32'(m == 1 ? mph[m][3-i] : mph[m][i]);
    return w;
  endfunction

  task automatic cycle(input logic vi, input logic fi, input logic [7:0] di,
                       input logic wri, output logic rdy);
    logic acc, e, comp;
    @(negedge clk);
    v = vi; f = fi; d = di; wr = wri;
    #1;
    for (int m = 0; m < 2; m++) begin
      erdy[m] = !(mlen[m] == 3 && mval[m] && !wri);
      chk(m == 0 ? "fwd_ready" : "rev_ready", 32'(o_rdy[m]), 32'(erdy[m]));
      chk(m == 0 ? "fwd_valid" : "rev_valid", 32'(o_val[m]), 32'(mval[m]));
      chk(m == 0 ? "fwd_data"  : "rev_data",  o_word[m], mword[m]);
      chk(m == 0 ? "fwd_error" : "rev_error", 32'(o_err[m]), 32'(merr[m]));
    end
    rdy = o_rdy[0];
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      acc = vi && erdy[m];
      e = 1'b0; comp = 1'b0;
      if (acc) begin
        if (fi) begin
          if (mlen[m] != 0) e = 1'b1;
          mph[m][0] = di; mlen[m] = 1;
        end else if (mlen[m] == 0) begin
          e = 1'b1;
        end else begin
          mph[m][mlen[m]] = di; mlen[m]++;
        end
        if (mlen[m] == 4) begin
          comp = 1'b1; mlen[m] = 0;
        end
      end
      if (comp) begin
        mval[m] = 1'b1; mword[m] = assemble(m);
      end else if (mval[m] && wri) begin
        mval[m] = 1'b0;
      end
      merr[m] = e;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    v = 1'b0; f = 1'b0; d = '0; wr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", 32'(o_val[m]), 32'd0);
      chk("rst_data",  o_word[m], 32'd0);
      chk("rst_error", 32'(o_err[m]), 32'd0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic r;
    int   cyc, first_pulse, pulses, last_pulse;
    vectors = 0; miscompares = 0;
    rst_n = 1'b1; v = 1'b0; f = 1'b0; d = '0; wr = 1'b1;
    model_reset();
    #3 rst_n = 1'b0;
    do_reset();

    // Plain word, both orders.
    cycle(1, 1, 8'hA1, 1, r); cycle(1, 0, 8'hB2, 1, r);
    cycle(1, 0, 8'hC3, 1, r); cycle(1, 0, 8'hD4, 1, r);
    #1;
    chk("t1_valid", 32'(o_val[0]), 32'd1);
    chk("t1_fwd",   o_word[0], 32'hA1B2C3D4);
    chk("t2_rev",   o_word[1], 32'hD4C3B2A1);
    cycle(0, 0, 8'h00, 1, r);
    #1 chk("t1_pulse", 32'(o_val[0]), 32'd0);

    // Backpressure: word held while the next word's last phit stalls.
    cycle(1, 1, 8'hA1, 1, r); cycle(1, 0, 8'hB2, 1, r);
    cycle(1, 0, 8'hC3, 1, r); cycle(1, 0, 8'hD4, 1, r);
    cycle(1, 1, 8'h11, 0, r); cycle(1, 0, 8'h22, 0, r);
    cycle(1, 0, 8'h33, 0, r);
    cycle(1, 0, 8'h44, 0, r); chk("t3_stall", 32'(r), 32'd0);
    cycle(1, 0, 8'h44, 0, r); chk("t3_stall2", 32'(r), 32'd0);
    #1 chk("t3_hold", o_word[0], 32'hA1B2C3D4);
    cycle(1, 0, 8'h44, 1, r); chk("t3_release", 32'(r), 32'd1);
    #1 chk("t3_word2", o_word[0], 32'h11223344);
    cycle(0, 0, 8'h00, 1, r);

    // Framing: resync on an early first marker, then a stray phit.
    cycle(1, 1, 8'hA1, 1, r); cycle(1, 0, 8'hB2, 1, r);
    cycle(1, 1, 8'hC3, 1, r);
    #1 chk("t4_err_resync", 32'(o_err[0]), 32'd1);
    cycle(1, 0, 8'hD4, 1, r); cycle(1, 0, 8'hE5, 1, r);
    cycle(1, 0, 8'hF6, 1, r);
    #1 chk("t4_word", o_word[0], 32'hC3D4E5F6);
    cycle(0, 0, 8'h00, 1, r);
    cycle(1, 0, 8'h77, 1, r);
    #1 chk("t4_err_stray", 32'(o_err[0]), 32'd1);
    chk("t4_no_word", 32'(o_val[0]), 32'd0);
    cycle(0, 0, 8'h00, 1, r);

    // Reset mid-word discards the partial word.
    cycle(1, 1, 8'h0A, 1, r); cycle(1, 0, 8'h0B, 1, r);
    do_reset();
    cycle(1, 1, 8'h01, 1, r); cycle(1, 0, 8'h02, 1, r);
    cycle(1, 0, 8'h03, 1, r); cycle(1, 0, 8'h04, 1, r);
    #1 chk("t5_word", o_word[0], 32'h01020304);
    cycle(0, 0, 8'h00, 1, r);

    // Throughput: eight phits back-to-back give two words four cycles apart.
    pulses = 0; first_pulse = -1; last_pulse = -1;
    for (int i = 0; i < 9; i++) begin
      cycle(i < 8, (i % 4) == 0, 8'(8'h10 + i), 1, r);
      if (i < 8) chk("t6_ready", 32'(r), 32'd1);
      #1;
      if (o_val[0]) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
      end
    end
    chk("t6_pulses", 32'(pulses), 32'd2);
    chk("t6_spacing", 32'(last_pulse - first_pulse), 32'd4);

    // Randomized traffic with occasional framing faults and backpressure.
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rv, rf, rw;
      rv = ($urandom_range(3) != 0);
      rf = (mlen[0] == 0);
      if ($urandom_range(15) == 0) rf = !rf;
      rw = ($urandom_range(3) != 0);
      cycle(rv, rf, 8'($urandom), rw, r);
      if (i == 1500) do_reset();
      cyc++;
    end
    cycle(0, 0, 8'h00, 1, r);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/c_phit_deserializer.md
Name: c_phit_deserializer

Overview:
Receive-side width converter for narrow links. It accepts a stream of phit_width-bit phits, with valid/ready handshaking and a first-phit marker, and reassembles them into width-bit words. The phit order is selectable: normal, or reversed to undo a transmitter that sends the last phit first. It sits between a narrow channel receiver and the full-width flit/word logic. It provides a one-word output register with backpressure.

Parameters:
- width, 32, output word width in bits; width % phit_width == 0 is required.
- phit_width, 8, input phit width in bits; 1 <= phit_width <= width.
- reverse_order, 0, phit placement order: 0 = first phit to word[0:phit_width-1]; 1 = first phit to word[width-phit_width:width-1].
- Derived, not settable: num_phits = width/phit_width; cnt_width = max(1, clogb(num_phits)).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- phit_valid_in  input  1  phit present
- phit_first_in  input  1  phit is the first of a word; qualified by phit_valid_in
- phit_data_in  input  [0:phit_width-1]  phit payload
- phit_ready_out  output  1  phit accepted when phit_valid_in && phit_ready_out
- word_valid_out  output  1  reassembled word held
- word_data_out  output  [0:width-1]  reassembled word
- word_ready_in  input  1  downstream consumes the word when valid && ready
- error_out  output  1  one-cycle pulse on a framing error

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset). While reset is low:
  - cnt = 0
  - assembly buffer = 0
  - word_valid_out = 0
  - word_data_out = 0
  - error_out = 0
- Reset mid-word discards the partial word. Reset with a word held discards that word; no output is produced for it.
- State:
  - phit counter cnt, range 0..num_phits-1.
  - Assembly buffer of width-phit_width bits; the last phit is not buffered.
  - Output register plus word_valid_out.
- Accept: acc = phit_valid_in && phit_ready_out.
- Ready rule: phit_ready_out = !(cnt == num_phits-1 && word_valid_out && !word_ready_in). This is combinational and independent of phit_valid_in.
- Placement: slot k = cnt, or cnt forced to 0 on a resync.
  - reverse_order=0: phit goes to bits [k*phit_width : (k+1)*phit_width-1].
  - reverse_order=1: phit goes to slot num_phits-1-k.
  - Bit order within a phit is never changed.
- Completion: an accepted phit at cnt == num_phits-1:
  - loads the output register with buffer merged with that phit;
  - sets word_valid_out on the next edge;
  - sets cnt to 0.
- Latency and throughput:
  - Latency is one cycle from accepting the last phit to word_valid_out = 1.
  - Full throughput is sustained: one phit per cycle, one word per num_phits cycles, no bubbles while word_ready_in = 1.
- Output: word_valid_out clears on a consume unless a new word completes in the same cycle; in that case the new word replaces the old one and valid stays 1. word_data_out holds stable while valid && !ready.
- Framing errors (error_out = 1 on the cycle after the offending accept):
  - acc && phit_first_in && cnt != 0: the partial word is discarded and the phit is taken as slot 0 (cnt becomes 1, or a word completes if num_phits == 1).
  - acc && !phit_first_in && cnt == 0: the phit is dropped and cnt stays 0.
- num_phits == 1: cnt is constant 0, each accepted phit is a word, and the first-phit marker is still checked.
- Unused buffer bits are not required to be cleared between words.

Decomposition:
- Shared constants/functions come from the existing clib include files: clogb, and the reset-polarity constants.
- No new package types are needed.
- One sub-module is natural: c_phit_slot_mux, a combinational slot-index-to-bit-range placement that honours reverse_order. The counter and output register are inline.

Test Plan:
1. width=32, phit=8, reverse_order=0. Send A1(first), B2, C3, D4 back-to-back with word_ready_in=1 -> word_data_out=32'hA1B2C3D4 with valid for 1 cycle, one cycle after D4; error_out stays 0.
2. Same phits with reverse_order=1 -> word_data_out=32'hD4C3B2A1.
3. Hold word_ready_in=0 after word 1, then send 11(first), 22, 33, 44 -> 11, 22, 33 are accepted; phit_ready_out=0 while 44 is offered; word 1 is held stable. Raise ready -> word 1 is consumed, 44 is accepted that cycle, and 32'h11223344 is valid the next cycle.
4. Framing: send A1(first), B2, then C3 with first=1, then D4, E5, F6 -> error pulse; output 32'hC3D4E5F6. Then send 77 without first at cnt=0 -> error pulse, phit dropped, no word.
5. Reset low asynchronously after 2 of 4 phits, then release and send a full word 01..04 -> all outputs 0 during reset; only 32'h01020304 is produced.
6. Throughput: 8 back-to-back phits with valid=1 and ready=1 -> 2 words, phit_ready_out=1 on every cycle, and word_valid_out pulses exactly 4 cycles apart.
